// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, control and divider hazards.
// Define HAZARD_PERF_EN to build the stall_cycles performance counter.
module hazard_ctrl #(
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_jump,
    input  logic        id_is_div,
    input  logic        id_reads_hilo,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        div_start,
    output logic        div_busy,
    output logic [31:0] stall_cycles
);

    typedef enum logic [0:0] {StRun, StDivBusy} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             div_hazard;

    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    assign div_hazard = (state_q == StDivBusy) && (id_reads_hilo || id_is_div);

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        div_start  = 1'b0;
        div_busy   = (state_q == StDivBusy);
        if (!reset) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            div_busy   = 1'b0;
        end else if (ex_branch_taken) begin
            // ID holds a wrong-path instruction, so nothing below may act on it.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use || div_hazard) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end else begin
            ifid_flush = id_jump;
            div_start  = (state_q == StRun) && id_is_div;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (div_start) begin
                    state_d = StDivBusy;
                    cnt_d   = CNT_W'(DIV_LAT);
                end
            end
            StDivBusy: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (!pc_we && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign stall_cycles = perf_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
